// File: rtl/game_pkg.sv
// -----------------------------------------------------------------------------
// game_pkg
// Shared definitions for the game collision logic.
//   state_t     : hit_manager FSM encoding (IDLE/SCAN/APPLY/DEAD)
//   coord_t     : one row or column coordinate at the default width
//   HP_MAX_DEF  : HP value loaded at reset unless overridden
//   idx_width() : width helper that never returns 0
// -----------------------------------------------------------------------------
package game_pkg;

  localparam int COORD_W_DEF = 10;
  localparam int HP_MAX_DEF  = 20;

  typedef logic [COORD_W_DEF-1:0] coord_t;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SCAN  = 2'd1,
    ST_APPLY = 2'd2,
    ST_DEAD  = 2'd3
  } state_t;

  // Bits needed to hold values 0..n-1, at least 1 bit.
  function automatic int idx_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/cell_window_cmp.sv
// -----------------------------------------------------------------------------
// cell_window_cmp
// Reports whether two grid cells lie within a square window of each other:
//   o_in = (|r0 - r1| <= LIMIT) && (|c0 - c1| <= LIMIT)
// Ports:
//   i_r0, i_c0 : first cell (row, column)
//   i_r1, i_c1 : second cell (row, column)
//   o_in       : 1 when the cells are inside the window
// Differences are taken in COORD_W+1 bits so coordinates near the top of the
// range never wrap into a false "near" result.
// -----------------------------------------------------------------------------
module cell_window_cmp #(
  parameter int COORD_W = 10,
  parameter int LIMIT   = 1
) (
  input  logic [COORD_W-1:0] i_r0,
  input  logic [COORD_W-1:0] i_c0,
  input  logic [COORD_W-1:0] i_r1,
  input  logic [COORD_W-1:0] i_c1,
  output logic               o_in
);

  localparam logic [COORD_W:0] LIM = (COORD_W+1)'(LIMIT);

  logic [COORD_W:0] w_dr;
  logic [COORD_W:0] w_dc;
  logic [COORD_W:0] w_abs_r;
  logic [COORD_W:0] w_abs_c;

  assign w_dr = {1'b0, i_r0} - {1'b0, i_r1};
  assign w_dc = {1'b0, i_c0} - {1'b0, i_c1};

  // MSB set means the difference went negative: negate it.
  assign w_abs_r = w_dr[COORD_W] ? (~w_dr + 1'b1) : w_dr;
  assign w_abs_c = w_dc[COORD_W] ? (~w_dc + 1'b1) : w_dc;

  assign o_in = (w_abs_r <= LIM) && (w_abs_c <= LIM);

endmodule

// File: rtl/hit_manager.sv
// -----------------------------------------------------------------------------
// hit_manager
// Per game tick, scans the monster channels one per cycle against the player
// cell, applies at most one point of damage (with invulnerability window) and
// kills monsters caught by a pending skill.
//
// Ports:
//   clk, rst          : clock, asynchronous active-low reset
//   tick              : one-cycle game tick; starts a scan from IDLE only
//   player_r/player_c : player cell, latched at scan start
//   mon_r/mon_c       : packed monster cells, channel i at [i*COORD_W +: COORD_W]
//   mon_alive         : per-channel alive flags
//   skill_fire        : one-cycle skill request, held pending until consumed
//   hp, player_alive  : player HP and hp != 0
//   hit_pulse         : one cycle high in APPLY when damage is taken
//   kill_mask         : one cycle in APPLY, channels killed by the skill
//   busy              : high in SCAN and APPLY
//   dbg_state         : current FSM state
//
// Handshake: tick and skill_fire are fire-and-forget strobes with no ready;
// a tick seen while busy (or dead) is dropped, a skill_fire is remembered.
//
// Build option: define HIT_MANAGER_REGEN_EN to regain 1 HP (up to HP_MAX)
// every 32 ticks without damage.
// -----------------------------------------------------------------------------
module hit_manager
  import game_pkg::*;
#(
  parameter int N_MON      = 4,
  parameter int COORD_W    = COORD_W_DEF,
  parameter int HP_W       = 5,
  parameter int HP_MAX     = HP_MAX_DEF,
  parameter int HIT_DIST   = 1,
  parameter int SKILL_DIST = 3,
  parameter int INV_TICKS  = 8
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     tick,
  input  logic [COORD_W-1:0]       player_r,
  input  logic [COORD_W-1:0]       player_c,
  input  logic [N_MON*COORD_W-1:0] mon_r,
  input  logic [N_MON*COORD_W-1:0] mon_c,
  input  logic [N_MON-1:0]         mon_alive,
  input  logic                     skill_fire,
  output logic [HP_W-1:0]          hp,
  output logic                     player_alive,
  output logic                     hit_pulse,
  output logic [N_MON-1:0]         kill_mask,
  output logic                     busy,
  output state_t                   dbg_state
);

  localparam int IDX_W = idx_width(N_MON);
  localparam int INV_W = idx_width(INV_TICKS + 1);

  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(N_MON - 1);
  localparam logic [INV_W-1:0] INV_LOAD = INV_W'(INV_TICKS);
  localparam logic [HP_W-1:0]  HP_RST   = HP_W'(HP_MAX);

  // FSM
  state_t r_state;
  state_t w_next;

  // Scan context
  logic [IDX_W-1:0]   r_idx;
  logic [COORD_W-1:0] r_pr;
  logic [COORD_W-1:0] r_pc;
  logic               r_skill_pend;  // request waiting for the next scan
  logic               r_skill_act;   // skill armed for the scan in progress
  logic [N_MON-1:0]   r_kill_acc;
  logic               r_hit_acc;

  // Player status
  logic [HP_W-1:0]  r_hp;
  logic [INV_W-1:0] r_inv;

  // Current channel
  logic [COORD_W-1:0] w_mr;
  logic [COORD_W-1:0] w_mc;
  logic               w_malive;
  logic               w_hit_win;
  logic               w_skill_win;
  logic               w_scan;
  logic               w_kill;
  logic               w_hit;
  logic               w_do_hit;
  logic               w_tick_live;

  assign w_mr     = mon_r[r_idx*COORD_W +: COORD_W];
  assign w_mc     = mon_c[r_idx*COORD_W +: COORD_W];
  assign w_malive = mon_alive[r_idx];

  cell_window_cmp #(
    .COORD_W (COORD_W),
    .LIMIT   (HIT_DIST)
  ) u_hit_cmp (
    .i_r0 (r_pr),
    .i_c0 (r_pc),
    .i_r1 (w_mr),
    .i_c1 (w_mc),
    .o_in (w_hit_win)
  );

  cell_window_cmp #(
    .COORD_W (COORD_W),
    .LIMIT   (SKILL_DIST)
  ) u_skill_cmp (
    .i_r0 (r_pr),
    .i_c0 (r_pc),
    .i_r1 (w_mr),
    .i_c1 (w_mc),
    .o_in (w_skill_win)
  );

  assign w_scan = (r_state == ST_SCAN);
  assign w_kill = w_scan && r_skill_act && w_malive && w_skill_win;
  // A monster killed this scan cannot also hurt the player.
  assign w_hit  = w_scan && w_malive && w_hit_win && !w_kill;

  assign w_do_hit = (r_state == ST_APPLY) && r_hit_acc &&
                    (r_inv == '0) && (r_hp != '0);

  // Ticks still age invulnerability/regen while busy, even though they are
  // dropped as scan triggers.
  assign w_tick_live = tick && (r_state != ST_DEAD);

  // ---------------------------------------------------------------------------
  // FSM
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) r_state <= ST_IDLE;
    else      r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      ST_IDLE:  if (tick) w_next = ST_SCAN;
      ST_SCAN:  if (r_idx == LAST_IDX) w_next = ST_APPLY;
      ST_APPLY: w_next = (w_do_hit && (r_hp == HP_W'(1))) ? ST_DEAD : ST_IDLE;
      ST_DEAD:  w_next = ST_DEAD;
      default:  w_next = ST_IDLE;
    endcase
  end

  // ---------------------------------------------------------------------------
  // Scan datapath
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_idx        <= '0;
      r_pr         <= '0;
      r_pc         <= '0;
      r_skill_pend <= 1'b0;
      r_skill_act  <= 1'b0;
      r_kill_acc   <= '0;
      r_hit_acc    <= 1'b0;
    end else begin
      if (skill_fire && (r_state != ST_DEAD)) r_skill_pend <= 1'b1;
      case (r_state)
        ST_IDLE: begin
          if (tick) begin
            r_pr        <= player_r;
            r_pc        <= player_c;
            r_idx       <= '0;
            r_kill_acc  <= '0;
            r_hit_acc   <= 1'b0;
            // Hand the pending request to this scan; a fire in the same
            // cycle as the tick is consumed too.
            r_skill_act  <= r_skill_pend || skill_fire;
            r_skill_pend <= 1'b0;
          end
        end
        ST_SCAN: begin
          r_idx             <= r_idx + 1'b1;
          r_kill_acc[r_idx] <= w_kill;
          if (w_hit) r_hit_acc <= 1'b1;
        end
        ST_APPLY: r_skill_act <= 1'b0;
        default: ;
      endcase
    end
  end

  // ---------------------------------------------------------------------------
  // HP, invulnerability and optional regeneration
  // ---------------------------------------------------------------------------
`ifdef HIT_MANAGER_REGEN_EN
  localparam logic [4:0] REGEN_LAST = 5'd31;
  logic [4:0] r_regen_cnt;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst)             r_regen_cnt <= '0;
    else if (w_do_hit)    r_regen_cnt <= '0;
    else if (w_tick_live) r_regen_cnt <= r_regen_cnt + 1'b1;  // wraps every 32
  end
`endif

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_hp  <= HP_RST;
      r_inv <= '0;
    end else begin
      if (w_do_hit)                          r_inv <= INV_LOAD;
      else if (w_tick_live && r_inv != '0)   r_inv <= r_inv - 1'b1;
`ifdef HIT_MANAGER_REGEN_EN
      if (w_do_hit)
        r_hp <= r_hp - 1'b1;
      else if (w_tick_live && (r_regen_cnt == REGEN_LAST) && (r_hp < HP_RST))
        r_hp <= r_hp + 1'b1;
`else
      if (w_do_hit) r_hp <= r_hp - 1'b1;
`endif
    end
  end

  // ---------------------------------------------------------------------------
  // Outputs
  // ---------------------------------------------------------------------------
  assign hp           = r_hp;
  assign player_alive = (r_hp != '0);
  assign hit_pulse    = w_do_hit;
  assign kill_mask    = (r_state == ST_APPLY) ? r_kill_acc : '0;
  assign busy         = (r_state == ST_SCAN) || (r_state == ST_APPLY);
  assign dbg_state    = r_state;

endmodule

// File: tb/tb_hit_manager.sv
// -----------------------------------------------------------------------------
// tb_hit_manager
// Directed bench for hit_manager (N_MON=4, COORD_W=10, HP_W=5, HP_MAX=20).
// Define HIT_MANAGER_REGEN_EN for both bench and RTL to check regeneration.
// -----------------------------------------------------------------------------
module tb_hit_manager;
  import game_pkg::*;

  localparam int N_MON   = 4;
  localparam int COORD_W = 10;
  localparam int HP_W    = 5;

  logic                     clk = 1'b0;
  logic                     rst = 1'b0;
  logic                     tick = 1'b0;
  logic                     skill_fire = 1'b0;
  logic [COORD_W-1:0]       player_r = '0;
  logic [COORD_W-1:0]       player_c = '0;
  logic [N_MON*COORD_W-1:0] mon_r = '0;
  logic [N_MON*COORD_W-1:0] mon_c = '0;
  logic [N_MON-1:0]         mon_alive = '0;
  logic [HP_W-1:0]          hp;
  logic                     player_alive;
  logic                     hit_pulse;
  logic [N_MON-1:0]         kill_mask;
  logic                     busy;
  state_t                   dbg_state;

  int n_cmp  = 0;
  int n_fail = 0;

  hit_manager dut (
    .clk          (clk),
    .rst          (rst),
    .tick         (tick),
    .player_r     (player_r),
    .player_c     (player_c),
    .mon_r        (mon_r),
    .mon_c        (mon_c),
    .mon_alive    (mon_alive),
    .skill_fire   (skill_fire),
    .hp           (hp),
    .player_alive (player_alive),
    .hit_pulse    (hit_pulse),
    .kill_mask    (kill_mask),
    .busy         (busy),
    .dbg_state    (dbg_state)
  );

  // clock / reset
  always #5 clk = ~clk;

  task automatic apply_reset();
    @(negedge clk);
    rst = 1'b0; tick = 1'b0; skill_fire = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
  endtask

  // driver tasks
  task automatic set_player(input int r, input int c);
    player_r = COORD_W'(r);
    player_c = COORD_W'(c);
  endtask

  task automatic set_mon(input int ch, input int r, input int c);
    mon_r[ch*COORD_W +: COORD_W] = COORD_W'(r);
    mon_c[ch*COORD_W +: COORD_W] = COORD_W'(c);
  endtask

  // One tick-started scan. hit_at is the sample (1 = first cycle after the
  // tick cycle) where hit_pulse was seen, 0 if never; kills ORs kill_mask.
  task automatic run_scan(input bit pre_skill, input bit mid_skill,
                          output int hit_at, output logic [N_MON-1:0] kills,
                          output bit timeout);
    hit_at = 0; kills = '0; timeout = 1'b1;
    if (pre_skill) begin
      @(negedge clk); skill_fire = 1'b1;
    end
    @(negedge clk); skill_fire = 1'b0; tick = 1'b1;
    @(negedge clk); tick = 1'b0; skill_fire = mid_skill;
    for (int i = 1; i <= 20; i++) begin
      if (hit_pulse === 1'b1) hit_at = i;
      kills = kills | kill_mask;
      if (busy === 1'b0) begin
        timeout = 1'b0;
        break;
      end
      @(negedge clk);
      skill_fire = 1'b0;
    end
  endtask

  task automatic test_reset();
    n_cmp++; if (hp !== 5'd20) begin n_fail++; $display("FAIL reset_hp: got %0d want 20", hp); end
    n_cmp++; if (player_alive !== 1'b1) begin n_fail++; $display("FAIL reset_alive: got %b want 1", player_alive); end
    n_cmp++; if (busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy: got %b want 0", busy); end
    n_cmp++; if (hit_pulse !== 1'b0) begin n_fail++; $display("FAIL reset_hit: got %b want 0", hit_pulse); end
    n_cmp++; if (kill_mask !== 4'b0000) begin n_fail++; $display("FAIL reset_kill: got %b want 0000", kill_mask); end
    n_cmp++; if (dbg_state !== ST_IDLE) begin n_fail++; $display("FAIL reset_state: got %0d want %0d", dbg_state, ST_IDLE); end
  endtask

  task automatic test_hit_and_invuln();
    int ha; logic [N_MON-1:0] km; bit to;
    apply_reset();
    set_player(5, 5); set_mon(0, 5, 6); mon_alive = 4'b0001;
    run_scan(1'b0, 1'b0, ha, km, to);
    n_cmp++; if (to !== 1'b0) begin n_fail++; $display("FAIL hit_timeout: got %b want 0", to); end
    n_cmp++; if (ha != N_MON + 1) begin n_fail++; $display("FAIL hit_latency: got %0d want %0d", ha, N_MON + 1); end
    n_cmp++; if (hp !== 5'd19) begin n_fail++; $display("FAIL hit_hp: got %0d want 19", hp); end
    n_cmp++; if (km !== 4'b0000) begin n_fail++; $display("FAIL hit_kill: got %b want 0000", km); end
    // Invulnerability 8 after the hit; each later scan's tick removes one.
    for (int s = 2; s <= 8; s++) begin
      run_scan(1'b0, 1'b0, ha, km, to);
      n_cmp++; if (ha != 0 || hp !== 5'd19) begin
        n_fail++; $display("FAIL inv_hold scan %0d: hit_at %0d hp %0d want 0 / 19", s, ha, hp);
      end
    end
    run_scan(1'b0, 1'b0, ha, km, to);
    n_cmp++; if (ha != N_MON + 1) begin n_fail++; $display("FAIL inv_expire_hit: got %0d want %0d", ha, N_MON + 1); end
    n_cmp++; if (hp !== 5'd18) begin n_fail++; $display("FAIL inv_expire_hp: got %0d want 18", hp); end
  endtask

  task automatic test_skill();
    int ha; logic [N_MON-1:0] km; bit to;
    apply_reset();
    set_player(5, 5);
    set_mon(0, 0, 0); set_mon(1, 5, 6); set_mon(2, 7, 8); set_mon(3, 5, 9);
    mon_alive = 4'b1101;
    run_scan(1'b1, 1'b0, ha, km, to);
    n_cmp++; if (km !== 4'b0100) begin n_fail++; $display("FAIL skill_kill: got %b want 0100", km); end
    n_cmp++; if (ha != 0 || hp !== 5'd20) begin n_fail++; $display("FAIL skill_nohit: hit_at %0d hp %0d want 0 / 20", ha, hp); end
    // Channel 1 overlaps the player but is killed, so it must not hurt.
    mon_alive = 4'b1111;
    run_scan(1'b1, 1'b0, ha, km, to);
    n_cmp++; if (km !== 4'b0110) begin n_fail++; $display("FAIL skill_overlap_kill: got %b want 0110", km); end
    n_cmp++; if (ha != 0 || hp !== 5'd20) begin n_fail++; $display("FAIL skill_overlap_nohit: hit_at %0d hp %0d want 0 / 20", ha, hp); end
    // Skill arriving mid-scan is held for the following scan.
    mon_alive = 4'b1101;
    run_scan(1'b0, 1'b1, ha, km, to);
    n_cmp++; if (km !== 4'b0000) begin n_fail++; $display("FAIL skill_mid_scan: got %b want 0000", km); end
    run_scan(1'b0, 1'b0, ha, km, to);
    n_cmp++; if (km !== 4'b0100) begin n_fail++; $display("FAIL skill_held: got %b want 0100", km); end
    // Pending flag is consumed: channel 1 now collides normally.
    mon_alive = 4'b0010;
    run_scan(1'b0, 1'b0, ha, km, to);
    n_cmp++; if (km !== 4'b0000 || hp !== 5'd19) begin n_fail++; $display("FAIL skill_consumed: kill %b hp %0d want 0000 / 19", km, hp); end
  endtask

  task automatic test_boundary();
    int ha; logic [N_MON-1:0] km; bit to;
    apply_reset();
    set_player(0, 0);
    set_mon(0, 1023, 0); set_mon(1, 1, 1); set_mon(2, 2, 0); set_mon(3, 1023, 1023);
    mon_alive = 4'b1101;
    run_scan(1'b0, 1'b0, ha, km, to);
    n_cmp++; if (ha != 0 || hp !== 5'd20) begin n_fail++; $display("FAIL bound_far: hit_at %0d hp %0d want 0 / 20", ha, hp); end
    mon_alive = 4'b1111;
    run_scan(1'b0, 1'b0, ha, km, to);
    n_cmp++; if (ha != N_MON + 1 || hp !== 5'd19) begin n_fail++; $display("FAIL bound_edge: hit_at %0d hp %0d want %0d / 19", ha, hp, N_MON + 1); end
  endtask

  task automatic test_back_to_back();
    int hits; int busy_after; bit done;
    apply_reset();
    set_player(5, 5); set_mon(0, 5, 5); mon_alive = 4'b0001;
    hits = 0; busy_after = 0; done = 1'b0;
    @(negedge clk); tick = 1'b1;
    @(negedge clk); tick = 1'b0;
    @(negedge clk); tick = 1'b1;   // lands in SCAN, must be dropped
    @(negedge clk); tick = 1'b0;
    for (int i = 0; i < 20; i++) begin
      if (hit_pulse === 1'b1) hits++;
      if (busy === 1'b0) begin done = 1'b1; break; end
      @(negedge clk);
    end
    n_cmp++; if (done !== 1'b1) begin n_fail++; $display("FAIL drop_timeout: got %b want 1", done); end
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (busy === 1'b1) busy_after++;
      if (hit_pulse === 1'b1) hits++;
    end
    n_cmp++; if (busy_after != 0) begin n_fail++; $display("FAIL drop_busy: got %0d busy cycles want 0", busy_after); end
    n_cmp++; if (hits != 1 || hp !== 5'd19) begin n_fail++; $display("FAIL drop_hits: hits %0d hp %0d want 1 / 19", hits, hp); end
  endtask

  task automatic test_death();
    int ha; logic [N_MON-1:0] km; bit to;
    int hits; int tos; int busy_cnt;
    apply_reset();
    set_player(5, 5); set_mon(0, 5, 6); mon_alive = 4'b0001;
    hits = 0; tos = 0;
    // Hits land on scans 1, 9, ..., 145: nineteen of them.
    for (int k = 0; k < 152; k++) begin
      run_scan(1'b0, 1'b0, ha, km, to);
      if (ha != 0) hits++;
      if (to) tos++;
    end
    n_cmp++; if (hits != 19 || tos != 0) begin n_fail++; $display("FAIL death_ramp: hits %0d timeouts %0d want 19 / 0", hits, tos); end
    n_cmp++; if (hp !== 5'd1 || player_alive !== 1'b1) begin n_fail++; $display("FAIL death_hp1: hp %0d alive %b want 1 / 1", hp, player_alive); end
    run_scan(1'b0, 1'b0, ha, km, to);
    n_cmp++; if (ha != N_MON + 1) begin n_fail++; $display("FAIL death_hit: got %0d want %0d", ha, N_MON + 1); end
    n_cmp++; if (hp !== 5'd0 || player_alive !== 1'b0) begin n_fail++; $display("FAIL death_hp0: hp %0d alive %b want 0 / 0", hp, player_alive); end
    n_cmp++; if (dbg_state !== ST_DEAD) begin n_fail++; $display("FAIL death_state: got %0d want %0d", dbg_state, ST_DEAD); end
    busy_cnt = 0;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk); tick = i[0]; skill_fire = ~i[0];
      if (busy === 1'b1 || hit_pulse === 1'b1 || kill_mask !== 4'b0000) busy_cnt++;
    end
    @(negedge clk); tick = 1'b0; skill_fire = 1'b0;
    n_cmp++; if (busy_cnt != 0 || hp !== 5'd0) begin n_fail++; $display("FAIL dead_ignore: activity %0d hp %0d want 0 / 0", busy_cnt, hp); end
  endtask

  task automatic test_reset_mid_scan();
    int ha; logic [N_MON-1:0] km; bit to;
    apply_reset();
    set_player(5, 5); set_mon(0, 5, 6); mon_alive = 4'b0001;
    run_scan(1'b0, 1'b0, ha, km, to);   // hp 19, invulnerable
    @(negedge clk); tick = 1'b1; skill_fire = 1'b1;
    @(negedge clk); tick = 1'b0; skill_fire = 1'b0;
    @(negedge clk);
    n_cmp++; if (busy !== 1'b1) begin n_fail++; $display("FAIL midrst_pre_busy: got %b want 1", busy); end
    rst = 1'b0;
    #1;
    n_cmp++; if (hp !== 5'd20 || player_alive !== 1'b1) begin n_fail++; $display("FAIL midrst_hp: hp %0d alive %b want 20 / 1", hp, player_alive); end
    n_cmp++; if (busy !== 1'b0 || hit_pulse !== 1'b0 || kill_mask !== 4'b0000) begin
      n_fail++; $display("FAIL midrst_outs: busy %b hit %b kill %b want 0 0 0000", busy, hit_pulse, kill_mask);
    end
    n_cmp++; if (dbg_state !== ST_IDLE) begin n_fail++; $display("FAIL midrst_state: got %0d want %0d", dbg_state, ST_IDLE); end
    @(negedge clk); rst = 1'b1;
    @(negedge clk);
    // Invulnerability and skill pending were cleared, so this hits at once
    // and kills nothing.
    run_scan(1'b0, 1'b0, ha, km, to);
    n_cmp++; if (ha != N_MON + 1 || hp !== 5'd19 || km !== 4'b0000) begin
      n_fail++; $display("FAIL midrst_after: hit_at %0d hp %0d kill %b want %0d / 19 / 0000", ha, hp, km, N_MON + 1);
    end
  endtask

  task automatic test_regen();
    int ha; logic [N_MON-1:0] km; bit to;
    logic [HP_W-1:0] exp_hp;
`ifdef HIT_MANAGER_REGEN_EN
    exp_hp = 5'd20;
`else
    exp_hp = 5'd19;
`endif
    apply_reset();
    set_player(5, 5); set_mon(0, 5, 6); mon_alive = 4'b0001;
    run_scan(1'b0, 1'b0, ha, km, to);
    mon_alive = 4'b0000;
    for (int k = 0; k < 31; k++) run_scan(1'b0, 1'b0, ha, km, to);
    n_cmp++; if (hp !== 5'd19) begin n_fail++; $display("FAIL regen_31: got %0d want 19", hp); end
    run_scan(1'b0, 1'b0, ha, km, to);
    n_cmp++; if (hp !== exp_hp) begin n_fail++; $display("FAIL regen_32: got %0d want %0d", hp, exp_hp); end
    for (int k = 0; k < 40; k++) run_scan(1'b0, 1'b0, ha, km, to);
    n_cmp++; if (hp !== exp_hp) begin n_fail++; $display("FAIL regen_hold: got %0d want %0d", hp, exp_hp); end
  endtask

  initial begin
    repeat (2) @(negedge clk);
    test_reset();
    rst = 1'b1;
    @(negedge clk);
    test_reset();
    test_hit_and_invuln();
    test_skill();
    test_boundary();
    test_back_to_back();
    test_death();
    test_reset_mid_scan();
    test_regen();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

  // Absolute guard so a stuck run still ends with a summary.
  initial begin
    #2000000;
    n_fail++;
    $display("FAIL global_timeout: sim time exceeded");
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
